bht_upd_ctrl: RTL
=================

BHT_UPD_CTRL -- requirements
Module: bht_upd_ctrl

Interface
REQ-001 The block SHALL have parameter LINE_NUM, default 1024, meaning the number of history-table lines.
REQ-002 The block SHALL have parameter WIDTH, default 6, meaning the history bits per line.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning the update queue entries (power of two, >=2).
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, reset: asynchronous, active-low.
REQ-006 Port stall, input, 1, pipeline stall: freezes the table write port.
REQ-007 Port upd_valid, input, 1, a resolved-branch update is offered.
REQ-008 Port upd_ready, output, 1, the queue accepts an update this cycle.
REQ-009 Port upd_idx, input, $clog2(LINE_NUM), the table line to update.
REQ-010 Port upd_taken, input, 1, the resolved direction bit.
REQ-011 Port flush_req, input, 1, a single-cycle pulse requesting a full table clear.
REQ-012 Port flush_busy, output, 1, a table clear is in progress.
REQ-013 Port bht_wen, output, 1, the table write enable.
REQ-014 Port bht_waddr, output, $clog2(LINE_NUM), the table write line.
REQ-015 Port bht_wdata, output, 1, the bit shifted into the line.
REQ-016 Port lookup_idx, input, $clog2(LINE_NUM), the line being predicted this cycle.
REQ-017 Port lookup_pend, output, 1, a queued update targets lookup_idx (present only with the macro below).

Function
REQ-018 The block SHALL implement a DEPTH-entry FIFO of {idx, taken}, with a push when upd_valid & upd_ready.
REQ-019 upd_ready SHALL be 1 only when the FSM is IDLE and the FIFO is not full; there is no same-cycle pass-through when full.
REQ-020 The FSM SHALL have two states: IDLE and SWEEP.
REQ-021 In IDLE with the FIFO non-empty and stall=0, the block SHALL drive bht_wen=1, bht_waddr=head.idx and bht_wdata=head.taken, and pop the head that cycle.
REQ-022 In IDLE with the FIFO empty or stall=1, bht_wen SHALL be 0 and the FIFO head SHALL be held.
REQ-023 Minimum latency from push to bht_wen SHALL be 1 cycle; updates SHALL drain in strict push order at 1 per non-stalled cycle.
REQ-024 A simultaneous push and pop SHALL both occur, leaving the FIFO count unchanged.
REQ-025 The FIFO pointers SHALL wrap modulo DEPTH, with a count of 0..DEPTH distinguishing full from empty.
REQ-026 flush_req in IDLE SHALL move the FSM to SWEEP next cycle, discard all FIFO entries, and suppress any drain in the request cycle.
REQ-027 In SWEEP, the block SHALL drive bht_wen=1, bht_wdata=0 and bht_waddr=line counter; this SHALL be held while stall=1.
REQ-028 In SWEEP, each non-stalled cycle SHALL increment a shift counter 0..WIDTH-1; on wrap, the line counter SHALL increment.
REQ-029 The sweep SHALL issue exactly LINE_NUM*WIDTH non-stalled writes.
REQ-030 After the write at line LINE_NUM-1 / shift WIDTH-1, the FSM SHALL return to IDLE with both counters at 0.
REQ-031 flush_busy SHALL be 1 exactly while in SWEEP; flush_req during SWEEP SHALL be ignored.
REQ-032 While in SWEEP, upd_valid SHALL be ignored (upd_ready=0).

Reset
REQ-033 Asserting rst low SHALL immediately force: FSM IDLE, FIFO empty, all counters 0, upd_ready=1, flush_busy=0, bht_wen=0, bht_waddr=0, bht_wdata=0, lookup_pend=0.
REQ-034 Reset during SWEEP SHALL abort the sweep with no further writes.

Configuration
REQ-035 Macro BHT_UPD_CTRL_PEND_EN defined: lookup_pend SHALL be the combinational OR over valid FIFO entries of (entry.idx == lookup_idx); a head entry popped this cycle still counts.
REQ-036 Macro BHT_UPD_CTRL_PEND_EN undefined: the lookup_pend port and its comparators SHALL be absent; lookup_idx SHALL be unused.

Verification
REQ-037 Push {idx=5,taken=1} with the FIFO empty and stall=0 -> next cycle bht_wen=1, waddr=5, wdata=1; then bht_wen=0.
REQ-038 Push 4 updates (idx 1,2,3,4) with stall=1 -> upd_ready=0 after the 4th; release stall -> writes 1,2,3,4 on 4 consecutive cycles, upd_ready=1 from the 2nd cycle after release.
REQ-039 LINE_NUM=4, WIDTH=2: pulse flush_req with 2 entries queued -> flush_busy for 8 cycles, waddr sequence 0,0,1,1,2,2,3,3 with wdata=0, queued entries never written.
REQ-040 Assert stall for 3 cycles mid-sweep -> bht_wen and waddr held, total sweep writes still LINE_NUM*WIDTH.
REQ-041 With the macro defined, queue idx=9 and set lookup_idx=9 -> lookup_pend=1; after idx=9 drains, lookup_pend=0.
REQ-042 Drive rst low mid-sweep at line 2 -> same cycle flush_busy=0 and bht_wen=0; after release, upd_ready=1.

Source files
------------

// File: rtl/bht_upd_ctrl.sv
// bht_upd_ctrl: queues resolved-branch history updates and drains them into the BHT write port; also runs a full-table clear sweep.
// Optional macro BHT_UPD_CTRL_PEND_EN adds lookup_pend, flagging queued updates that target lookup_idx.
`default_nettype none

module bht_upd_ctrl #(
  parameter int LINE_NUM = 1024,
  parameter int WIDTH    = 6,
  parameter int DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        upd_valid,
  output logic                        upd_ready,
  input  logic [$clog2(LINE_NUM)-1:0] upd_idx,
  input  logic                        upd_taken,
  input  logic                        flush_req,
  output logic                        flush_busy,
  output logic                        bht_wen,
  output logic [$clog2(LINE_NUM)-1:0] bht_waddr,
  output logic                        bht_wdata,
  input  logic [$clog2(LINE_NUM)-1:0] lookup_idx
`ifdef BHT_UPD_CTRL_PEND_EN
  ,
  output logic                        lookup_pend
`endif
);

  localparam int IW = $clog2(LINE_NUM);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] fifo_idx_q [DEPTH];
  logic          fifo_tk_q  [DEPTH];
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW:0]   count_q, count_d;
  logic [IW-1:0] line_q, line_d;
  logic [SW-1:0] shift_q, shift_d;
  logic          push;
  logic          pop;

  always_comb begin
    state_d    = state_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    line_d     = line_q;
    shift_d    = shift_q;
    upd_ready  = 1'b0;
    flush_busy = 1'b0;
    bht_wen    = 1'b0;
    bht_waddr  = '0;
    bht_wdata  = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        upd_ready = (count_q != (PW+1)'(DEPTH));
        // A flush wins over everything: queued and same-cycle updates are dropped.
        if (flush_req) begin
          state_d = SWEEP;
          rptr_d  = '0;
          wptr_d  = '0;
          count_d = '0;
        end else begin
          push = upd_valid & upd_ready;
          pop  = (count_q != '0) && !stall;
          if (pop) begin
            bht_wen   = 1'b1;
            bht_waddr = fifo_idx_q[rptr_q];
            bht_wdata = fifo_tk_q[rptr_q];
            rptr_d    = rptr_q + PW'(1);
          end
          if (push) begin
            wptr_d = wptr_q + PW'(1);
          end
          count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
      end
      SWEEP: begin
        flush_busy = 1'b1;
        bht_wen    = 1'b1;
        bht_waddr  = line_q;
        if (!stall) begin
          if (shift_q == SW'(WIDTH - 1)) begin
            shift_d = '0;
            if (line_q == IW'(LINE_NUM - 1)) begin
              line_d  = '0;
              state_d = IDLE;
            end else begin
              line_d = line_q + IW'(1);
            end
          end else begin
            shift_d = shift_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      line_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      line_q  <= line_d;
      shift_q <= shift_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx_q[wptr_q] <= upd_idx;
      fifo_tk_q[wptr_q]  <= upd_taken;
    end
  end

`ifdef BHT_UPD_CTRL_PEND_EN
  logic [DEPTH-1:0] hit;

  // An entry is live when its distance from the head is below the count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_pend
    logic [PW-1:0] off;
    assign off    = PW'(g) - rptr_q;
    assign hit[g] = ({1'b0, off} < count_q) && (fifo_idx_q[g] == lookup_idx);
  end

  assign lookup_pend = |hit;
`else
  logic unused_lookup_idx;
  assign unused_lookup_idx = ^lookup_idx;
`endif

endmodule

`default_nettype wire
